// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst master: FSM state encoding,
// mode bit positions and width helpers.
package spi_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A single slave still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with one extra pointer bit for
// full/empty. A push on a full FIFO is taken only when a pop happens in the same cycle.
module spi_sync_fifo
    import spi_burst_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = rd_en && !empty;
    assign w_push  = wr_en && (!full || w_pop);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_burst_master.sv
// SPI master streaming words from a TX FIFO into bursts under one slave select.
// Optional SPI_BURST_LOOPBACK_EN adds a loopback input (mosi -> sampler, ss_n held high).
//
// state | meaning
// IDLE  | no frame, ss_n all high, waiting for TX data
// LEAD  | slave selected, one half-period before the first sck edge
// SHIFT | 2*WORD_LEN sck half-periods, one word shifted out and in
// TRAIL | after a word: chain the next word or release ss_n after a half-period
module spi_burst_master
    import spi_burst_pkg::*;
#(
    parameter int WORD_LEN   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS     = 2,
    parameter int DIV_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_LEN-1:0]      tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [WORD_LEN-1:0]      rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    input  logic [sel_w(NUM_CS)-1:0] cs_sel,
    input  logic [DIV_W-1:0]         prescaler,
    input  logic [1:0]               mode,
    input  logic                     lsbfirst,
    input  logic                     ovf_clr,
    output logic                     busy,
    output logic                     rx_overflow,
    output logic                     sck,
    output logic                     mosi,
    input  logic                     miso,
`ifdef SPI_BURST_LOOPBACK_EN
    input  logic                     loopback,
`endif
    output logic [NUM_CS-1:0]        ss_n
);

    localparam int CSW  = sel_w(NUM_CS);
    localparam int EC_W = $clog2(2 * WORD_LEN);

    spi_state_e          r_state;
    logic [CSW-1:0]      r_cs;
    logic [DIV_W-1:0]    r_presc;
    logic [DIV_W-1:0]    r_hp_cnt;
    logic [1:0]          r_mode;
    logic                r_lsb;
    logic [WORD_LEN-1:0] r_tx_sr;
    logic [WORD_LEN-1:0] r_rx_sr;
    logic [EC_W-1:0]     r_edge_cnt;
    logic                r_lead;
    logic                r_rx_push;
    logic                r_ovf;
    logic                r_sck;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_ss_n;
`ifdef SPI_BURST_LOOPBACK_EN
    logic                r_lpbk;
`endif

    logic                w_tx_push;
    logic                w_tx_pop;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic [WORD_LEN-1:0] w_tx_head;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic                w_hp_tick;
    logic                w_cpha;
    logic                w_edge;
    logic                w_sample_edge;
    logic                w_update_edge;
    logic                w_rx_bit;
    logic                w_load_lsb;
    logic                w_head_bit;
    logic [WORD_LEN-1:0] w_head_shift;
    logic                w_out_bit;
    logic [WORD_LEN-1:0] w_sr_next;
    logic [NUM_CS-1:0]   w_ss_sel;
    logic [NUM_CS-1:0]   w_ss_start;

    assign w_tx_push = tx_valid && !w_tx_full;
    assign w_tx_pop  = ((r_state == ST_LEAD) && w_hp_tick) ||
                       ((r_state == ST_TRAIL) && !w_tx_empty);

    spi_sync_fifo #(.WIDTH(WORD_LEN), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_tx_push),
        .wr_data (tx_data),
        .full    (w_tx_full),
        .rd_en   (w_tx_pop),
        .rd_data (w_tx_head),
        .empty   (w_tx_empty)
    );

    spi_sync_fifo #(.WIDTH(WORD_LEN), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_rx_push),
        .wr_data (r_rx_sr),
        .full    (w_rx_full),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .empty   (w_rx_empty)
    );

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign busy        = (r_state != ST_IDLE);
    assign rx_overflow = r_ovf;
    assign sck         = r_sck;
    assign mosi        = r_mosi;
    assign ss_n        = r_ss_n;

    assign w_hp_tick = (r_hp_cnt == '0);
    assign w_cpha    = r_mode[MODE_CPHA];
    assign w_edge    = (r_state == ST_SHIFT) && w_hp_tick;
    // r_lead marks the first edge of each bit; CPHA picks which edge samples.
    assign w_sample_edge = w_edge && (r_lead ^ w_cpha);
    assign w_update_edge = w_edge && !(r_lead ^ w_cpha) && (r_edge_cnt != '0);

    assign w_load_lsb   = (r_state == ST_IDLE) ? lsbfirst : r_lsb;
    assign w_head_bit   = w_load_lsb ? w_tx_head[0] : w_tx_head[WORD_LEN-1];
    assign w_head_shift = w_load_lsb ? (w_tx_head >> 1) : (w_tx_head << 1);
    assign w_out_bit    = r_lsb ? r_tx_sr[0] : r_tx_sr[WORD_LEN-1];
    assign w_sr_next    = r_lsb ? (r_tx_sr >> 1) : (r_tx_sr << 1);

`ifdef SPI_BURST_LOOPBACK_EN
    assign w_rx_bit   = r_lpbk ? r_mosi : miso;
    assign w_ss_start = loopback ? '1 : w_ss_sel;
`else
    assign w_rx_bit   = miso;
    assign w_ss_start = w_ss_sel;
`endif

    always_comb begin
        w_ss_sel = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (cs_sel == CSW'(i)) w_ss_sel[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cs       <= '0;
            r_presc    <= '0;
            r_hp_cnt   <= '0;
            r_mode     <= '0;
            r_lsb      <= 1'b0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_edge_cnt <= '0;
            r_lead     <= 1'b1;
            r_rx_push  <= 1'b0;
            r_ovf      <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_ss_n     <= '1;
`ifdef SPI_BURST_LOOPBACK_EN
            r_lpbk     <= 1'b0;
`endif
        end else begin
            r_rx_push <= 1'b0;
            // A word landing in a full RX FIFO with no pop is lost; set wins over clear.
            if (r_rx_push && w_rx_full && !rx_ready) r_ovf <= 1'b1;
            else if (ovf_clr)                        r_ovf <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_sck  <= r_mode[MODE_CPOL];
                    r_mosi <= 1'b1;
                    r_ss_n <= '1;
                    if (!w_tx_empty) begin
                        r_state  <= ST_LEAD;
                        r_cs     <= cs_sel;
                        r_presc  <= prescaler;
                        r_mode   <= mode;
                        r_lsb    <= lsbfirst;
                        r_hp_cnt <= prescaler;
                        r_sck    <= mode[MODE_CPOL];
                        r_ss_n   <= w_ss_start;
`ifdef SPI_BURST_LOOPBACK_EN
                        r_lpbk   <= loopback;
`endif
                        if (mode[MODE_CPHA]) begin
                            r_tx_sr <= w_tx_head;
                        end else begin
                            r_tx_sr <= w_head_shift;
                            r_mosi  <= w_head_bit;
                        end
                    end
                end
                ST_LEAD: begin
                    if (w_hp_tick) begin
                        r_state    <= ST_SHIFT;
                        r_hp_cnt   <= r_presc;
                        r_edge_cnt <= EC_W'(2 * WORD_LEN - 1);
                        r_lead     <= 1'b1;
                    end else begin
                        r_hp_cnt <= r_hp_cnt - DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (w_hp_tick) begin
                        r_sck    <= ~r_sck;
                        r_lead   <= ~r_lead;
                        r_hp_cnt <= r_presc;
                        if (w_sample_edge)
                            r_rx_sr <= r_lsb ? {w_rx_bit, r_rx_sr[WORD_LEN-1:1]}
                                             : {r_rx_sr[WORD_LEN-2:0], w_rx_bit};
                        if (w_update_edge) begin
                            r_mosi  <= w_out_bit;
                            r_tx_sr <= w_sr_next;
                        end
                        if (r_edge_cnt == '0) begin
                            r_state   <= ST_TRAIL;
                            r_rx_push <= 1'b1;
                        end else begin
                            r_edge_cnt <= r_edge_cnt - EC_W'(1);
                        end
                    end else begin
                        r_hp_cnt <= r_hp_cnt - DIV_W'(1);
                    end
                end
                ST_TRAIL: begin
                    if (!w_tx_empty) begin
                        r_state    <= ST_SHIFT;
                        r_hp_cnt   <= r_presc;
                        r_edge_cnt <= EC_W'(2 * WORD_LEN - 1);
                        r_lead     <= 1'b1;
                        if (w_cpha) begin
                            r_tx_sr <= w_tx_head;
                        end else begin
                            r_tx_sr <= w_head_shift;
                            r_mosi  <= w_head_bit;
                        end
                    end else if (w_hp_tick) begin
                        r_state <= ST_IDLE;
                        r_ss_n  <= '1;
                        r_mosi  <= 1'b1;
                    end else begin
                        r_hp_cnt <= r_hp_cnt - DIV_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed bench for spi_burst_master (default parameters); loopback case only
// when SPI_BURST_LOOPBACK_EN is defined.
module tb_spi_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [0:0] cs_sel;
    logic [7:0] prescaler;
    logic [1:0] mode;
    logic       lsbfirst;
    logic       ovf_clr;
    logic       busy;
    logic       rx_overflow;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [1:0] ss_n;
    logic       ext_loop;
    logic       miso_drv;
`ifdef SPI_BURST_LOOPBACK_EN
    logic       loopback;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign miso = ext_loop ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_burst_master dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cs_sel      (cs_sel),
        .prescaler   (prescaler),
        .mode        (mode),
        .lsbfirst    (lsbfirst),
        .ovf_clr     (ovf_clr),
        .busy        (busy),
        .rx_overflow (rx_overflow),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
`ifdef SPI_BURST_LOOPBACK_EN
        .loopback    (loopback),
`endif
        .ss_n        (ss_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("push_timeout", {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Watches one frame from the current sample; mosi is captured at each sck rise.
    task automatic run_frame(input bit lsb, input bit chg,
                             output int low0, output int low1, output int rises,
                             output int span, output logic [15:0] cap);
        int   cyc;
        int   first;
        int   last;
        bit   seen;
        logic psck;
        logic plow;
        cyc = 0; first = -1; last = -1; rises = 0; cap = '0;
        low0 = ss_n[0] ? 0 : 1;
        low1 = ss_n[1] ? 0 : 1;
        seen = busy;
        psck = sck;
        plow = (ss_n != 2'b11);
        for (int k = 0; k < 400; k++) begin
            tick();
            cyc++;
            if (busy) seen = 1'b1;
            if (chg && cyc == 3) begin
                cs_sel    = 1'b1;
                prescaler = 8'd7;
                lsbfirst  = ~lsbfirst;
            end
            if (!ss_n[0]) low0++;
            if (!ss_n[1]) low1++;
            if (!psck && sck && plow) begin
                rises++;
                if (first < 0) first = cyc;
                last = cyc;
                cap  = lsb ? {mosi, cap[15:1]} : {cap[14:0], mosi};
            end
            psck = sck;
            plow = (ss_n != 2'b11);
            if (seen && !busy) break;
        end
        chk("frame_end", {31'd0, busy}, 32'd0);
        span = last - first;
    endtask

    initial begin
        int          low0, low1, rises, span, n;
        logic [15:0] cap;

        rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        cs_sel = '0; prescaler = 8'd1; mode = 2'b00; lsbfirst = 1'b0;
        ovf_clr = 1'b0; ext_loop = 1'b1; miso_drv = 1'b0;
`ifdef SPI_BURST_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_ovf",      {31'd0, rx_overflow}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_ss_n",     {30'd0, ss_n}, 32'd3);
        chk("rst_sck",      {31'd0, sck}, 32'd0);
        chk("rst_mosi",     {31'd0, mosi}, 32'd1);
        rst = 1'b0;
        tick();

        // Mode 0, MSB first, 0xA5; config inputs are disturbed mid-frame.
        push(8'hA5);
        run_frame(1'b0, 1'b1, low0, low1, rises, span, cap);
        chk("m0_rises",   rises, 8);
        chk("m0_span",    span, 28);
        chk("m0_mosi",    {16'd0, cap}, 32'h00A5);
        chk("m0_ss0_low", low0, 36);
        chk("m0_ss1_low", low1, 0);
        chk("m0_sck_idle", {31'd0, sck}, 32'd0);
        chk("m0_mosi_idle", {31'd0, mosi}, 32'd1);
        chk("m0_rx_valid", {31'd0, rx_valid}, 32'd1);
        pop_chk("m0_rx_data", 8'hA5);
        chk("m0_rx_empty", {31'd0, rx_valid}, 32'd0);

        // Mode 3, LSB first, two chained words on slave 1.
        cs_sel = 1'b1; prescaler = 8'd1; mode = 2'b11; lsbfirst = 1'b1;
        push(8'h40);
        push(8'h01);
        run_frame(1'b1, 1'b0, low0, low1, rises, span, cap);
        chk("m3_rises",   rises, 16);
        chk("m3_mosi",    {16'd0, cap}, 32'h0140);
        chk("m3_span",    span, 61);
        chk("m3_ss1_low", low1, 69);
        chk("m3_ss0_low", low0, 0);
        chk("m3_sck_idle", {31'd0, sck}, 32'd1);
        pop_chk("m3_rx0", 8'h40);
        pop_chk("m3_rx1", 8'h01);

        // TX back-pressure with a long lead half-period.
        cs_sel = 1'b0; prescaler = 8'd255; mode = 2'b00; lsbfirst = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("bp_full", {31'd0, tx_ready}, 32'd0);
        tx_data = 8'h99; tx_valid = 1'b1;
        repeat (10) tick();
        chk("bp_hold", {31'd0, tx_ready}, 32'd0);
        n = 0;
        while (!tx_ready && n < 400) begin
            tick();
            n++;
        end
        chk("bp_reopen", {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
        chk("bp_refull", {31'd0, tx_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bp_rst_ready", {31'd0, tx_ready}, 32'd1);

        // RX overflow: five words, no pops.
        prescaler = 8'd0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        wait_idle("ovf_idle");
        tick();
        chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
        pop_chk("ovf_rx0", 8'h11);
        pop_chk("ovf_rx1", 8'h22);
        pop_chk("ovf_rx2", 8'h33);
        pop_chk("ovf_rx3", 8'h44);
        chk("ovf_rx_empty", {31'd0, rx_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, rx_overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, rx_overflow}, 32'd0);

        // Reset during bit 3.
        prescaler = 8'd1;
        push(8'hFF);
        rises = 0;
        n = 0;
        while (rises < 3 && n < 200) begin
            logic p;
            p = sck;
            tick();
            if (!p && sck) rises++;
            n++;
        end
        chk("ab_reach_bit3", rises, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_ss_n",  {30'd0, ss_n}, 32'd3);
        chk("ab_sck",   {31'd0, sck}, 32'd0);
        chk("ab_busy",  {31'd0, busy}, 32'd0);
        chk("ab_rx",    {31'd0, rx_valid}, 32'd0);
        repeat (20) tick();
        chk("ab_no_push", {31'd0, rx_valid}, 32'd0);

`ifdef SPI_BURST_LOOPBACK_EN
        ext_loop = 1'b0; miso_drv = 1'b0; loopback = 1'b1;
        push(8'h3C);
        run_frame(1'b0, 1'b0, low0, low1, rises, span, cap);
        chk("lb_ss_low", low0 + low1, 0);
        pop_chk("lb_rx", 8'h3C);
        loopback = 1'b0; ext_loop = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_burst_master.md
SPI_BURST_MASTER -- requirements
Module: spi_burst_master

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 8, bits per SPI word (4..32).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, entries per TX and RX FIFO (power of 2, >=2).
REQ-003 The block SHALL have parameter NUM_CS, default 2, number of slave-select outputs (1..8).
REQ-004 The block SHALL have parameter DIV_W, default 8, width of the prescaler input.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the only clock.
- rst  in  1  reset; synchronous and active-high.
- tx_data  in  WORD_LEN  word to send.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  WORD_LEN  head of the RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request.
- cs_sel  in  $clog2(NUM_CS)  target slave.
- prescaler  in  DIV_W  half-period = prescaler+1 clk cycles.
- mode  in  2  {CPOL,CPHA}.
- lsbfirst  in  1  1 = LSB first.
- ovf_clr  in  1  clears rx_overflow.
- busy  out  1  a frame is in progress.
- rx_overflow  out  1  sticky flag: a received word was dropped.
- sck  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- ss_n  out  NUM_CS  active-low slave selects.

Function
REQ-006 A TX push SHALL occur on a clk edge where tx_valid && tx_ready; when tx_ready=0, tx_valid SHALL be ignored and no data SHALL be lost or overwritten.
REQ-007 An RX pop SHALL occur where rx_valid && rx_ready; rx_data SHALL be the FIFO head (first-word fall-through).
REQ-008 The FSM SHALL have four states:
- IDLE -> LEAD when the TX FIFO is not empty.
- LEAD -> SHIFT after one half-period.
- SHIFT -> TRAIL after 2*WORD_LEN half-periods.
- TRAIL -> SHIFT (next word) when the TX FIFO is not empty; otherwise TRAIL -> IDLE after one half-period.
REQ-009 On IDLE->LEAD the block SHALL latch cs_sel, prescaler, mode and lsbfirst, and SHALL hold them for the whole frame; input changes during a frame SHALL take effect at the next frame only.
REQ-010 The block SHALL pop a TX word on entry to SHIFT.
REQ-011 In LEAD, ss_n[cs_sel] SHALL be low; with CPHA=0 the first bit SHALL be on mosi at LEAD entry.
REQ-012 sck SHALL equal CPOL outside SHIFT; in SHIFT it SHALL toggle every half-period.
REQ-013 miso SHALL be sampled on the leading edge when CPHA=0 and on the trailing edge when CPHA=1; mosi SHALL update on the opposite edge.
REQ-014 Back-to-back words SHALL keep ss_n asserted with no idle sck cycle inserted.
REQ-015 In IDLE, ss_n SHALL be all ones and mosi SHALL be 1.
REQ-016 Each completed word SHALL be pushed into the RX FIFO; if the RX FIFO is full, the word SHALL be dropped and rx_overflow SHALL be set.
REQ-017 rx_overflow SHALL clear only on ovf_clr or rst; a set and an ovf_clr in the same cycle SHALL leave it set.
REQ-018 A simultaneous push and pop on a full or empty FIFO SHALL be handled as the legal subset: on full, the pop proceeds first and the push is accepted; on empty, only the push proceeds.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and SHALL wrap modulo 2*FIFO_DEPTH.

Reset
REQ-021 On rst the block SHALL set: FSM=IDLE, both FIFOs empty, tx_ready=1, rx_valid=0, rx_overflow=0, busy=0, ss_n all ones, sck=0, mosi=1, latched mode=0.
REQ-022 An rst asserted mid-frame SHALL abort the frame immediately with no RX push, and all outputs SHALL reach their reset values at the next clk edge.

Configuration
REQ-023 With macro SPI_BURST_LOOPBACK_EN defined, the block SHALL add input loopback; when loopback=1 the sampler SHALL use internal mosi instead of miso and ss_n SHALL stay all ones.
REQ-024 With SPI_BURST_LOOPBACK_EN undefined, the block SHALL have no loopback port and SHALL always sample miso.

Structure
REQ-025 A shared package spi_burst_pkg SHALL hold the FSM state enum, the mode bit positions (CPOL=1, CPHA=0) and the helper constant for pointer width.
REQ-026 The block SHALL instantiate one sub-module, spi_sync_fifo (parametrised width/depth, full/empty flags), twice, once for TX and once for RX.

Verification
REQ-027 Mode 0, MSB first, prescaler=1, push 0xA5 with miso tied to mosi externally -> 8 sck pulses, 4 clk each, mosi 1,0,1,0,0,1,0,1, rx_data=0xA5, ss_n low for 1+16+1 half-periods.
REQ-028 Mode 3, LSB first, push 0x40 then 0x01 -> ss_n stays low across both words, sck idles high, mosi bit order LSB first.
REQ-029 Push 5 words with FIFO_DEPTH=4 while the bus is stalled -> tx_ready=0 after the 4th push; the 5th push is not accepted until a pop.
REQ-030 Never assert rx_ready and send 5 words -> 4 words held, rx_overflow=1; pulse ovf_clr -> rx_overflow=0.
REQ-031 Assert rst during bit 3 of a word -> next cycle ss_n all ones, sck=0, busy=0, rx_valid=0.
REQ-032 With SPI_BURST_LOOPBACK_EN defined, loopback=1, push 0x3C -> rx_data=0x3C and ss_n never asserted.
